// File: rtl/ifm_rx_arb_if.sv
// S2MM data and status stream bundle between the receive arbiter (master)
// and the DMA (slave).
interface ifm_rx_arb_if;
   logic [63:0] m_axis_s2mm_tdata;
   logic [7:0]  m_axis_s2mm_tkeep;
   logic        m_axis_s2mm_tlast;
   logic        m_axis_s2mm_tvalid;
   logic        m_axis_s2mm_tready;
   logic [31:0] m_axis_s2mm_sts_tdata;
   logic [3:0]  m_axis_s2mm_sts_tkeep;
   logic        m_axis_s2mm_sts_tlast;
   logic        m_axis_s2mm_sts_tvalid;
   logic        m_axis_s2mm_sts_tready;

   modport master (
      output m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast, m_axis_s2mm_tvalid,
      input  m_axis_s2mm_tready,
      output m_axis_s2mm_sts_tdata, m_axis_s2mm_sts_tkeep, m_axis_s2mm_sts_tlast,
      output m_axis_s2mm_sts_tvalid,
      input  m_axis_s2mm_sts_tready
   );

   modport slave (
      input  m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast, m_axis_s2mm_tvalid,
      output m_axis_s2mm_tready,
      input  m_axis_s2mm_sts_tdata, m_axis_s2mm_sts_tkeep, m_axis_s2mm_sts_tlast,
      input  m_axis_s2mm_sts_tvalid,
      output m_axis_s2mm_sts_tready
   );
endinterface

// File: rtl/ifm_rx_arb.sv
// Frame-atomic round-robin arbiter merging per-port FWFT data/status FIFO
// pairs onto the single S2MM data and status streams.
module ifm_rx_arb #(
   parameter int C_NUM_PORTS = 2,
   parameter int C_STS_WORDS = 6
) (
   input  logic                      s2mm_clk,
   input  logic                      s2mm_reset,
   input  logic [73*C_NUM_PORTS-1:0] dfifo_rdata,
   input  logic [C_NUM_PORTS-1:0]    dfifo_empty,
   output logic [C_NUM_PORTS-1:0]    dfifo_rden,
   input  logic [37*C_NUM_PORTS-1:0] cfifo_rdata,
   input  logic [C_NUM_PORTS-1:0]    cfifo_empty,
   output logic [C_NUM_PORTS-1:0]    cfifo_rden,
   ifm_rx_arb_if.master              axis,
   output logic                      sts_len_err,
   output logic [7:0]                ifm_rx_arb_dbg
);

   localparam int GW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_STS  = 2'd2,
      S_NEXT = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [GW-1:0]        grant, ptr, pick, cand;
   logic [C_NUM_PORTS-1:0] eligible;
   logic [3:0]           sts_cnt;
   logic [7:0]           frame_cnt;
   logic [72:0]          d_head;
   logic [36:0]          c_head;
   logic                 d_valid, c_valid, d_pop, c_pop;

   // A non-empty status FIFO means the whole frame's data is already buffered.
   assign eligible = ~cfifo_empty & ~dfifo_empty;

   assign d_head = dfifo_rdata[73*int'(grant) +: 73];
   assign c_head = cfifo_rdata[37*int'(grant) +: 37];

   assign axis.m_axis_s2mm_tdata      = d_head[63:0];
   assign axis.m_axis_s2mm_tkeep      = d_head[71:64];
   assign axis.m_axis_s2mm_tlast      = d_head[72];
   assign axis.m_axis_s2mm_tvalid     = d_valid;
   assign axis.m_axis_s2mm_sts_tdata  = c_head[31:0];
   assign axis.m_axis_s2mm_sts_tkeep  = c_head[35:32];
   assign axis.m_axis_s2mm_sts_tlast  = c_head[36];
   assign axis.m_axis_s2mm_sts_tvalid = c_valid;

   assign ifm_rx_arb_dbg = {frame_cnt[3:0], 2'(grant), state};

   // Round-robin search starting one past the last served port.
   always_comb begin
      pick = '0;
      cand = '0;
      for (int i = C_NUM_PORTS; i >= 1; i--) begin
         cand = GW'((int'(ptr) + i) % C_NUM_PORTS);
         if (eligible[cand]) pick = cand;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_nxt  = state;
      d_valid    = 1'b0;
      c_valid    = 1'b0;
      d_pop      = 1'b0;
      c_pop      = 1'b0;
      dfifo_rden = '0;
      cfifo_rden = '0;
      // Outputs are gated by reset so nothing is valid or popped while it is held.
      if (!s2mm_reset) begin
         unique case (state)
            S_IDLE: if (|eligible) state_nxt = S_DATA;
            S_DATA: begin
               d_valid           = ~dfifo_empty[grant];
               d_pop             = d_valid & axis.m_axis_s2mm_tready;
               dfifo_rden[grant] = d_pop;
               if (d_pop && d_head[72]) state_nxt = S_STS;
            end
            S_STS: begin
               c_valid           = ~cfifo_empty[grant];
               c_pop             = c_valid & axis.m_axis_s2mm_sts_tready;
               cfifo_rden[grant] = c_pop;
               if (c_pop && c_head[36]) state_nxt = S_NEXT;
            end
            S_NEXT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge s2mm_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (s2mm_reset) begin
         state       <= S_IDLE;
         grant       <= '0;
         ptr         <= GW'(C_NUM_PORTS - 1);
         sts_len_err <= 1'b0;
         frame_cnt   <= '0;
         sts_cnt     <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE) begin
            sts_cnt <= '0;
            if (|eligible) grant <= pick;
         end
         if (c_pop) begin
            sts_cnt <= sts_cnt + 4'd1;
            if (c_head[36] && (sts_cnt + 4'd1 != 4'(C_STS_WORDS))) sts_len_err <= 1'b1;
         end
         if (state == S_NEXT) begin
            ptr       <= grant;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/ifm_rx_arb.md
Name: ifm_rx_arb

Overview:
- Frame-atomic round-robin arbiter for the receive path.
- Merges C_NUM_PORTS per-port receive FIFO pairs onto the single S2MM AXI4-Stream data channel and the single S2MM status channel toward the DMA.
- Each port pair is a good-frame data FIFO and a ctrl/status FIFO, both FWFT, as written by the per-port receive output FSMs.
- A port is eligible only once its status words exist: the status FIFO is written after the frame's data, so a non-empty status FIFO means a whole frame is buffered.

Parameters:
C_NUM_PORTS, 2, number of receive ports arbitrated (1..4)
C_STS_WORDS, 6, status words expected per frame

Ports:
s2mm_clk  in  1  clock
s2mm_reset  in  1  synchronous, active-high reset
dfifo_rdata  in  73*C_NUM_PORTS  per port p, slice [73p+72:73p]: bit72 last, [71:64] keep, [63:0] data (FWFT)
dfifo_empty  in  C_NUM_PORTS  per-port data FIFO empty
dfifo_rden  out  C_NUM_PORTS  per-port data FIFO pop
cfifo_rdata  in  37*C_NUM_PORTS  per port p, slice [37p+36:37p]: bit36 last, [35:32] keep, [31:0] data (FWFT)
cfifo_empty  in  C_NUM_PORTS  per-port status FIFO empty
cfifo_rden  out  C_NUM_PORTS  per-port status FIFO pop
m_axis_s2mm_tdata  out  64  data beat
m_axis_s2mm_tkeep  out  8  byte enables
m_axis_s2mm_tlast  out  1  end of frame
m_axis_s2mm_tvalid  out  1  data valid
m_axis_s2mm_tready  in  1  DMA ready
m_axis_s2mm_sts_tdata  out  32  status word
m_axis_s2mm_sts_tkeep  out  4  status byte enables
m_axis_s2mm_sts_tlast  out  1  last status word
m_axis_s2mm_sts_tvalid  out  1  status valid
m_axis_s2mm_sts_tready  in  1  DMA status ready
sts_len_err  out  1  sticky: a status sequence length differed from C_STS_WORDS
ifm_rx_arb_dbg  out  8  [1:0] state, [3:2] grant, [7:4] frame count mod 16

Behaviour:
- Reset (synchronous, s2mm_reset=1 at the edge):
  - state S_IDLE; grant 0; round-robin pointer C_NUM_PORTS-1, so port 0 wins first.
  - sts_len_err 0; frame count 0; status word counter 0.
  - Every tvalid and every rden reads 0 during reset.
  - Reset mid-frame abandons the frame. FIFOs are not flushed; the remainder is replayed as a new frame.
- eligible[p] = ~cfifo_empty[p] & ~dfifo_empty[p].
- S_IDLE:
  - If any port is eligible, choose the first eligible port searching from pointer+1 with wrap-around.
  - Register the choice as grant and go to S_DATA. No output is valid in S_IDLE.
  - When nothing is eligible, stay in S_IDLE.
- S_DATA (combinational pass-through from FIFO head):
  - tvalid = ~dfifo_empty[grant]; tdata/tkeep/tlast = head fields of the granted port.
  - dfifo_rden[grant] = tvalid & tready. All other rden bits are 0.
  - Data FIFO empty mid-frame: tvalid=0, hold state, never switch ports.
  - On the popped beat with last=1, go to S_STS.
- S_STS:
  - sts_tvalid = ~cfifo_empty[grant]; sts tdata/tkeep/tlast = head fields; cfifo_rden[grant] = sts_tvalid & sts_tready.
  - A word counter (4 bits, cleared in S_IDLE) increments per popped word.
  - When the popped word has last=1 and count+1 != C_STS_WORDS, set sts_len_err. The frame still completes normally.
  - The arbiter never forces tlast.
  - After the last word is popped, go to S_NEXT.
- S_NEXT:
  - Pointer <= grant; frame count increments (8-bit internal, wraps); go to S_IDLE.
  - Neither stream is valid in this state.
- Tdata/tdata fields are don't-care while the matching tvalid=0; drive them from the granted port's head.
- Latency:
  - eligible seen in S_IDLE → first data beat valid the next cycle.
  - Back-to-back frames need a minimum of 2 idle cycles (S_NEXT, S_IDLE) between the status tlast and the next data beat.
- Frame atomicity: grant changes only in S_IDLE. At most one rden bit is high in any cycle, and data and status never pop in the same cycle.
- AXI rules: tvalid does not depend on tready. Held data stays stable while tvalid=1 & tready=0, because the FWFT head is unchanged without a pop.
- Single port (C_NUM_PORTS=1): grant is always 0; pointer logic degenerates.

Test Plan:
1. Port 0: 3-beat frame (last beat keep 0x0F) plus 6 status words, tready=1 → 3 data beats with tlast on beat 3; 6 sts beats with sts_tlast on word 6; dfifo_rden[0] pulses 3 times, cfifo_rden[0] 6 times; sts_len_err=0; dbg frame count=1.
2. Both ports hold 2 frames each, eligible from reset → grant order 0,1,0,1; no interleaving of beats between ports.
3. m_axis_s2mm_tready low 4 cycles during beat 2 → tdata/tvalid held constant, dfifo_rden=0 for those 4 cycles, beat 2 emitted once.
4. Data FIFO empties after beat 1 of 3 for 5 cycles while port 1 is eligible → tvalid=0, grant stays 0, beats 2–3 from port 0 follow, then port 1 is served.
5. Port 0 status sequence of 5 words with last on word 5 → sts_len_err=1 (sticky, survives subsequent good frames); next frame is delivered normally.
6. s2mm_reset pulsed while in S_DATA after 1 beat → next cycle all tvalid/rden=0, state S_IDLE; port 0 is re-granted first and the remaining beats emerge as a new frame.
